usb_packet_tx: RTL and testbench
================================

# usb_packet_tx

- Device-side USB packet transmitter: builds handshake and data packets and streams them byte-by-byte to the SIE transmit port.
- The device controller issues a request (PID plus payload length) and the block frames it: PID byte, payload, CRC16.
- Payload bytes are pulled from an endpoint buffer over a valid/ready handshake.
- It is the transmit counterpart of the token receiver and drives the SIE's `tx_data`/`tx_valid`/`tx_ready` interface.

## Interface
- `MAX_LEN`, default 64: maximum payload bytes per data packet. `LW = $clog2(MAX_LEN+1)`.
- `clk` in 1: system clock (24 MHz).
- `reset` in 1: reset, synchronous, active-high.
- `send` in 1: request strobe; accepted only when `busy`=0.
- `pid` in `pid_t` (4): PID of the packet, sampled with `send`.
- `len` in LW: payload byte count, sampled with `send`; ignored for handshake PIDs.
- `pl_data` in 8: payload byte.
- `pl_valid` in 1: `pl_data` valid.
- `pl_ready` out 1: block accepts `pl_data`; a transfer occurs when `pl_valid && pl_ready`.
- `tx_data` out 8: byte to SIE.
- `tx_valid` out 1: rise starts SYNC, high while bytes are pending, fall triggers EOP.
- `tx_ready` in 1: SIE has consumed the current `tx_data`.
- `busy` out 1: packet in progress.
- `done` out 1: one-cycle pulse, packet completed normally.
- `err` out 1: one-cycle pulse, request rejected or payload underrun.

## Operation
- States: IDLE, PID, DATA, CRC_LO, CRC_HI.
- PID byte is always `{~pid, pid}`. Examples: ACK D2, NAK 5A, STALL 1E, DATA0 C3, DATA1 4B.
- IDLE, `send`=1, valid request:
  - Load `tx_data`=PID byte and set `tx_valid`=1, `busy`=1.
  - Set `crc`=16'hFFFF and clear fetch/send counters.
  - Go to PID.
- Rejected request: `len`>MAX_LEN on a data PID, or PID rejected per Configuration.
  - `err`=1 for one cycle; stay in IDLE; `tx_valid` stays 0.
- Packet classes:
  - Handshake (ACK, NAK, STALL): PID byte only. PID with `tx_ready` → `tx_valid`=0, `done`=1, IDLE.
  - Data (DATA0, DATA1):
    - PID with `tx_ready` → DATA if `len`>0, else CRC_LO.
    - DATA advances byte by byte; the last payload byte consumed → CRC_LO.
    - CRC_LO with `tx_ready` → CRC_HI.
    - CRC_HI with `tx_ready` → `tx_valid`=0, `done`=1, IDLE.
- Payload holding register (one byte, `full` flag):
  - `pl_ready` = (state PID or DATA) && !`full` && fetched<`len`.
  - Combinational from registers only; no dependence on `pl_valid`.
  - Fetch writes the holding register, sets `full`, and updates `crc` over the byte, LSB first.
- DATA, `tx_ready`=1:
  - `tx_data` ← holding register and clear `full`, or bypass if loaded the same cycle.
  - If no byte is available: underrun. Set `tx_valid`=0, `err`=1, and go to IDLE. There is no `done` pulse; the host sees a CRC failure.
  - Entering DATA from PID is subject to the same availability check.
- CRC16 details:
  - Polynomial x^16+x^15+x^2+1, reflected (0xA001 right-shift form), init FFFF.
  - Transmitted value is `~crc`, low byte first.
  - Zero-length packet sends 00 00.
- `tx_data` holds steady while `tx_valid`=1 and `tx_ready`=0; no limit on stall length.

## Timing
- Reset values: `tx_data`=8'h00, `tx_valid`=0, `pl_ready`=0, `busy`=0, `done`=0, `err`=0, state IDLE, `full`=0.
- Request latency: the cycle after `send` shows `tx_valid`=1 with the PID byte.
- After a `tx_ready` cycle, the next byte is on `tx_data` on the following cycle.
- `done` and the `tx_valid` fall occur in the cycle after the final `tx_ready`; `busy`=0 in that same cycle.
- A new `send` in the `done` cycle is accepted.
- `send` while `busy`=1 is ignored; no error is raised.
- Byte budget: full speed is 16 clk per byte. The holding register must be filled within that time after the previous consume; the block prefetches the first byte during PID.
- Reset mid-packet: at the reset edge all outputs take their reset values. `tx_valid` drops without `done`; the SIE emits EOP, and the truncated packet is discarded by the host.
- Simultaneous `tx_ready` and payload fetch in DATA: the fetched byte is bypassed to `tx_data`, and `full` stays 0.

## Configuration
- `USB_TX_PID_CHECK_EN` defined:
  - Only ACK, NAK, STALL, DATA0 and DATA1 are accepted.
  - Any other PID (tokens, SOF, PRE, NYET, DATA2, MDATA, ...) pulses `err` and is not sent.
- Undefined:
  - Any PID is accepted.
  - `pid[1:0]`==2'b11 → data class (payload + CRC16); otherwise PID byte only.
  - The `len`>MAX_LEN check remains.

## Test plan
- ACK request, `tx_ready` pulsed each 16 clk → `tx_data` D2 for one byte, then `tx_valid`=0 and `done`=1 for one cycle.
- DATA0, `len`=0 → bytes C3, 00, 00, then `done`; `pl_ready` is never asserted.
- DATA1, `len`=9, payload 31..39 ("123456789") → 4B 31 32 33 34 35 36 37 38 39 C8 B4.
- DATA0, `len`=4, `pl_valid` withheld after 2 bytes → `err` pulse, `tx_valid` falls after byte 2, no `done`, `busy`=0.
- IN request (PID 1001), with `USB_TX_PID_CHECK_EN` → `err`=1, `tx_valid` stays 0. DATA0 with `len`=65 → `err`=1 in both builds.
- `reset` asserted during DATA byte 3 → next cycle all outputs are at reset values. A following ACK `send` produces D2 normally.

Source files
------------

// File: rtl/usb_packet_tx.sv
`default_nettype none
// ============================================================================
// Module   : usb_packet_tx
// Purpose  : Device-side USB packet transmitter. Frames handshake packets
//            (PID byte only) and data packets (PID, payload, CRC16) and
//            streams them byte by byte to the SIE transmit port.
// Ports    : clk, reset (sync, active-high)
//            send/pid/len        - packet request from the device controller
//            pl_data/pl_valid/pl_ready - payload from the endpoint buffer
//            tx_data/tx_valid/tx_ready - byte stream to the SIE
//            busy, done, err     - status (done/err are one-cycle pulses)
// Options  : USB_TX_PID_CHECK_EN - when defined, only ACK/NAK/STALL/DATA0/
//            DATA1 are accepted; anything else is rejected with err.
// Revision : 1.0 - initial release
// ============================================================================
module usb_packet_tx #(
    parameter int MAX_LEN = 64,
    localparam int LW = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          send,
    input  logic [3:0]    pid,
    input  logic [LW-1:0] len,
    input  logic [7:0]    pl_data,
    input  logic          pl_valid,
    output logic          pl_ready,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PID    = 3'd1,
        S_DATA   = 3'd2,
        S_CRC_LO = 3'd3,
        S_CRC_HI = 3'd4
    } state_t;

    localparam logic [LW-1:0] c_max_len = LW'(MAX_LEN);
    localparam logic [LW-1:0] c_one     = LW'(1);
    localparam logic [LW-1:0] c_zero    = '0;

    state_t        r_state;
    logic [7:0]    r_hold;
    logic          r_full;
    logic [15:0]   r_crc;
    logic [LW-1:0] r_len;
    logic [LW-1:0] r_fetched;   // payload bytes pulled from the buffer
    logic [LW-1:0] r_sent;      // payload bytes placed on tx_data
    logic          r_is_data;

    logic          w_is_data;
    logic          w_pid_ok;
    logic          w_accept;
    logic          w_fetch;
    logic          w_avail;
    logic [7:0]    w_next_byte;
    logic [15:0]   w_crc_upd;
    logic [15:0]   w_crc_tx;

    // Reflected CRC16 (0xA001), data consumed LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                               input logic [7:0]  data);
        logic [15:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ 16'hA001;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

`ifdef USB_TX_PID_CHECK_EN
    always_comb begin
        w_is_data = 1'b0;
        w_pid_ok  = 1'b0;
        case (pid)
            4'b0010, 4'b1010, 4'b1110: w_pid_ok = 1'b1;          // ACK, NAK, STALL
            4'b0011, 4'b1011: begin                             // DATA0, DATA1
                w_pid_ok  = 1'b1;
                w_is_data = 1'b1;
            end
            default: ;
        endcase
    end
`else
    assign w_is_data = (pid[1:0] == 2'b11);
    assign w_pid_ok  = 1'b1;
`endif

    assign w_accept = w_pid_ok && !(w_is_data && (len > c_max_len));

    // Depends on registers only so the buffer side never sees a comb loop.
    assign pl_ready = ((r_state == S_PID) || (r_state == S_DATA)) &&
                      !r_full && (r_fetched < r_len);

    assign w_fetch     = pl_valid && pl_ready;
    assign w_avail     = r_full || w_fetch;
    assign w_next_byte = r_full ? r_hold : pl_data;   // bypass when hold empty
    assign w_crc_upd   = crc16_byte(r_crc, pl_data);
    assign w_crc_tx    = ~r_crc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_hold    <= 8'h00;
            r_full    <= 1'b0;
            r_crc     <= 16'hFFFF;
            r_len     <= c_zero;
            r_fetched <= c_zero;
            r_sent    <= c_zero;
            r_is_data <= 1'b0;
            tx_data   <= 8'h00;
            tx_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;

            if (w_fetch) begin
                r_hold    <= pl_data;
                r_full    <= 1'b1;
                r_crc     <= w_crc_upd;
                r_fetched <= r_fetched + c_one;
            end

            case (r_state)
                S_IDLE: begin
                    if (send) begin
                        if (w_accept) begin
                            tx_data   <= {~pid, pid};
                            tx_valid  <= 1'b1;
                            busy      <= 1'b1;
                            r_crc     <= 16'hFFFF;
                            r_fetched <= c_zero;
                            r_sent    <= c_zero;
                            r_full    <= 1'b0;
                            r_len     <= w_is_data ? len : c_zero;
                            r_is_data <= w_is_data;
                            r_state   <= S_PID;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end

                S_PID, S_DATA: begin
                    if (tx_ready) begin
                        if ((r_state == S_PID) && !r_is_data) begin
                            tx_valid <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            r_state  <= S_IDLE;
                        end else if (r_sent == r_len) begin
                            // Payload exhausted (or zero-length): CRC follows.
                            tx_data <= w_crc_tx[7:0];
                            r_state <= S_CRC_LO;
                        end else if (w_avail) begin
                            // Clearing full also covers the bypass case.
                            tx_data <= w_next_byte;
                            r_full  <= 1'b0;
                            r_sent  <= r_sent + c_one;
                            r_state <= S_DATA;
                        end else begin
                            // Underrun: drop tx_valid so the SIE ends the packet.
                            tx_valid <= 1'b0;
                            busy     <= 1'b0;
                            err      <= 1'b1;
                            r_state  <= S_IDLE;
                        end
                    end
                end

                S_CRC_LO: begin
                    if (tx_ready) begin
                        tx_data <= w_crc_tx[15:8];
                        r_state <= S_CRC_HI;
                    end
                end

                S_CRC_HI: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_usb_packet_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_packet_tx
// Purpose  : Directed self-checking bench for usb_packet_tx. Inputs change
//            and outputs are sampled on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_packet_tx;

    localparam int MAX_LEN = 64;
    localparam int LW      = $clog2(MAX_LEN + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          send;
    logic [3:0]    pid;
    logic [LW-1:0] len;
    logic [7:0]    pl_data;
    logic          pl_valid;
    logic          pl_ready;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          busy;
    logic          done;
    logic          err;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] pay_q[$];

    always #5 clk = ~clk;

    usb_packet_tx #(.MAX_LEN(MAX_LEN)) dut (
        .clk      (clk),
        .reset    (reset),
        .send     (send),
        .pid      (pid),
        .len      (len),
        .pl_data  (pl_data),
        .pl_valid (pl_valid),
        .pl_ready (pl_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk($sformatf("%s/tx_data", tag),  16'(tx_data), 16'h00);
        chk($sformatf("%s/tx_valid", tag), 16'(tx_valid), 16'h0);
        chk($sformatf("%s/pl_ready", tag), 16'(pl_ready), 16'h0);
        chk($sformatf("%s/busy", tag),     16'(busy), 16'h0);
        chk($sformatf("%s/done", tag),     16'(done), 16'h0);
        chk($sformatf("%s/err", tag),      16'(err), 16'h0);
    endtask

    // Issues a request at the current falling edge and plays the SIE and the
    // endpoint buffer until the packet ends. Returns on the falling edge where
    // done/err is seen, so the next request lands in the done cycle.
    task automatic run_packet(input string tag, input logic [3:0] p, input int l,
                              input int avail, input int period, input int rst_after,
                              input logic exp_accept, input logic exp_done,
                              input logic exp_err, input logic exp_plr,
                              input int exp_pulled, input logic poke);
        logic [7:0] got[$];
        logic [7:0] prev_data;
        logic       prev_ready, finished, saw_done, saw_err, saw_plr, was_reset;
        int         idx, cnt;

        send = 1'b1; pid = p; len = LW'(l);
        @(negedge clk);
        send = 1'b0;
        if (!exp_accept) begin
            chk($sformatf("%s/rej_err", tag),   16'(err), 16'h1);
            chk($sformatf("%s/rej_valid", tag), 16'(tx_valid), 16'h0);
            chk($sformatf("%s/rej_busy", tag),  16'(busy), 16'h0);
            return;
        end
        chk($sformatf("%s/lat_valid", tag), 16'(tx_valid), 16'h1);
        chk($sformatf("%s/lat_pid", tag),   16'(tx_data), 16'({~p, p}));
        chk($sformatf("%s/lat_busy", tag),  16'(busy), 16'h1);

        prev_data = {~p, p}; prev_ready = 1'b0; finished = 1'b0;
        saw_done = 1'b0; saw_err = 1'b0; saw_plr = 1'b0; was_reset = 1'b0;
        idx = 0; cnt = 0;
        for (int k = 0; k < 3000 && !finished; k++) begin
            if (done || err || !tx_valid) begin
                finished = 1'b1; saw_done = done; saw_err = err;
                tx_ready = 1'b0; pl_valid = 1'b0; send = 1'b0;
                chk($sformatf("%s/end_after_ready", tag), 16'(prev_ready), 16'h1);
                chk($sformatf("%s/end_valid", tag), 16'(tx_valid), 16'h0);
                chk($sformatf("%s/end_busy", tag),  16'(busy), 16'h0);
            end else begin
                if (!prev_ready)
                    chk($sformatf("%s/stall_hold", tag), 16'(tx_data), 16'(prev_data));
                prev_data = tx_data;
                if (pl_ready) saw_plr = 1'b1;
                if (rst_after > 0 && got.size() == rst_after) begin
                    reset = 1'b1; tx_ready = 1'b0; pl_valid = 1'b0;
                    @(negedge clk);
                    chk_reset_values($sformatf("%s/midrst", tag));
                    reset = 1'b0; finished = 1'b1; was_reset = 1'b1;
                end else begin
                    tx_ready = ((cnt % period) == period - 1);
                    cnt++;
                    if (tx_ready) got.push_back(tx_data);
                    prev_ready = tx_ready;
                    pl_valid = (idx < avail);
                    pl_data  = pl_valid ? pay_q[idx] : 8'h00;
                    if (pl_valid && pl_ready) idx++;
                    if (poke && k == 3) begin
                        send = 1'b1; pid = 4'b0011; len = LW'(65);
                    end else begin
                        send = 1'b0;
                    end
                    @(negedge clk);
                end
            end
        end
        chk($sformatf("%s/finished", tag), 16'(finished), 16'h1);
        if (!was_reset) begin
            chk($sformatf("%s/done", tag), 16'(saw_done), 16'(exp_done));
            chk($sformatf("%s/err", tag),  16'(saw_err), 16'(exp_err));
        end
        chk($sformatf("%s/pl_ready_seen", tag), 16'(saw_plr), 16'(exp_plr));
        if (exp_pulled >= 0)
            chk($sformatf("%s/pulled", tag), 16'(idx), 16'(exp_pulled));
        chk($sformatf("%s/nbytes", tag), 16'(got.size()), 16'(exp_q.size()));
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            chk($sformatf("%s/byte%0d", tag, i), 16'(got[i]), 16'(exp_q[i]));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; send = 1'b0; pid = 4'h0; len = '0;
        pl_data = 8'h00; pl_valid = 1'b0; tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_values("por");
        reset = 1'b0;

        // ACK, SIE pacing 16 clk per byte; a rejected-looking send while busy
        // must be ignored without err.
        exp_q = '{8'hD2}; pay_q = {};
        run_packet("ack", 4'b0010, 0, 0, 16, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1);

        // Zero-length DATA0: CRC of nothing is 0000 on the wire.
        exp_q = '{8'hC3, 8'h00, 8'h00};
        run_packet("data0_zlp", 4'b0011, 0, 0, 16, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);

        // DATA1 "123456789": CRC16-USB check value B4C8, low byte first.
        pay_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        exp_q = '{8'h4B, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                  8'h38, 8'h39, 8'hC8, 8'hB4};
        run_packet("data1_9", 4'b1011, 9, 9, 16, 0, 1'b1, 1'b1, 1'b0, 1'b1, 9, 1'b0);

        // Single byte 00, SIE ready every cycle: fetch bypasses the hold reg.
        pay_q = '{8'h00};
        exp_q = '{8'hC3, 8'h00, 8'h40, 8'hBF};
        run_packet("data0_1_fast", 4'b0011, 1, 1, 1, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1, 1'b0);

        // STALL with 2-clk pacing.
        exp_q = '{8'h1E}; pay_q = {};
        run_packet("stall", 4'b1110, 0, 0, 2, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);

        // Underrun: only 2 of 4 payload bytes ever offered.
        pay_q = '{8'h01, 8'h02};
        exp_q = '{8'hC3, 8'h01, 8'h02};
        run_packet("underrun", 4'b0011, 4, 2, 16, 0, 1'b1, 1'b0, 1'b1, 1'b1, 2, 1'b0);

        // Oversize data packet is rejected in every build.
        exp_q = {}; pay_q = {};
        run_packet("len65", 4'b0011, 65, 0, 16, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);

        // IN token PID.
`ifdef USB_TX_PID_CHECK_EN
        run_packet("in_pid", 4'b1001, 0, 0, 16, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
`else
        exp_q = '{8'h69};
        run_packet("in_pid", 4'b1001, 0, 0, 16, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
`endif

        // Reset while payload byte 3 is on tx_data.
        pay_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        exp_q = '{8'h4B, 8'h31, 8'h32};
        run_packet("midrst", 4'b1011, 9, 9, 16, 3, 1'b1, 1'b0, 1'b0, 1'b1, -1, 1'b0);

        // Normal operation resumes after the reset.
        exp_q = '{8'hD2}; pay_q = {};
        run_packet("ack_after_rst", 4'b0010, 0, 0, 16, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);

        // NAK sent in the done cycle of the previous packet.
        exp_q = '{8'h5A};
        run_packet("nak_b2b", 4'b1010, 0, 0, 3, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
